// File: rtl/ann_layer_sequencer.sv
// Layer sequencer for the multi-layer ANN datapath: launches each layer in turn,
// snapshots the final activations and reduces them to a signed argmax result.
module ann_layer_sequencer #(
  parameter int NUM_LAYERS     = 2,
  parameter int DATAWIDTH      = 11,
  parameter int OUT_ROWS       = 10,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int IDX_W         = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_overall_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic [NUM_LAYERS-1:0]         layer_skip_mask,
  output logic [NUM_LAYERS-1:0]         layer_start,
  input  logic [NUM_LAYERS-1:0]         layer_done,
  input  logic [OUT_ROWS*DATAWIDTH-1:0] final_vec,
  output logic                          busy,
  output logic                          result_valid,
  input  logic                          result_ready,
  output logic [IDX_W-1:0]              pred_index,
  output logic [OUT_ROWS-1:0]           pred_onehot,
  output logic [DATAWIDTH-1:0]          pred_value,
  output logic [DATAWIDTH:0]            pred_margin,
  output logic                          timeout_err
);

  localparam int CUR_W   = $clog2(NUM_LAYERS + 1);
  localparam int WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int WD_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  localparam logic [CUR_W-1:0]            CUR_END  = CUR_W'(NUM_LAYERS);
  localparam logic [IDX_W-1:0]            K_LAST   = IDX_W'(OUT_ROWS - 1);
  localparam logic [WD_W-1:0]             WD_END   = WD_W'(WD_LAST);
  localparam logic signed [DATAWIDTH-1:0] MOST_NEG = {1'b1, {(DATAWIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_SCAN,
    S_RESULT
  } state_t;

  state_t state, state_nxt;

  logic [CUR_W-1:0]            cur;
  logic [NUM_LAYERS-1:0]       skip_q;
  logic [WD_W-1:0]             wdog;
  logic [IDX_W-1:0]            k;
  logic [IDX_W-1:0]            idx_q;
  logic signed [DATAWIDTH-1:0] max_val;
  logic signed [DATAWIDTH-1:0] sec_val;
  logic signed [DATAWIDTH-1:0] snap [OUT_ROWS];

  logic [NUM_LAYERS-1:0]       cur_onehot;
  logic                        skip_hit;
  logic                        done_hit;
  logic                        cur_end;
  logic                        wd_expire;

  logic signed [DATAWIDTH-1:0] elem;
  logic                        gt_max;
  logic                        gt_sec;
  logic signed [DATAWIDTH-1:0] nxt_max;
  logic signed [DATAWIDTH-1:0] nxt_sec;
  logic [IDX_W-1:0]            nxt_idx;

  // Margin is formed one bit wider so max-minus-second never overflows;
  // a single-element vector has no runner-up, so its margin is defined as 0.
  function automatic logic [DATAWIDTH:0] margin_calc(
    input logic signed [DATAWIDTH-1:0] hi,
    input logic signed [DATAWIDTH-1:0] lo
  );
    logic [DATAWIDTH:0] diff;
    diff = {hi[DATAWIDTH-1], hi} - {lo[DATAWIDTH-1], lo};
    if (OUT_ROWS == 1) diff = '0;
    return diff;
  endfunction

  // cur_onehot is all-zero once cur reaches NUM_LAYERS, so no out-of-range select
  assign cur_onehot = NUM_LAYERS'(1) << cur;
  assign skip_hit   = |(cur_onehot & skip_q);
  assign done_hit   = |(cur_onehot & layer_done);
  assign cur_end    = (cur == CUR_END);
  assign wd_expire  = (TIMEOUT_CYCLES != 0) && (wdog == WD_END);

  // ---- argmax compare stage: one snapshot element per SCAN cycle ----
  always_comb begin
    elem    = snap[k];
    gt_max  = (elem > max_val);
    gt_sec  = (elem > sec_val);
    nxt_max = max_val;
    nxt_sec = sec_val;
    nxt_idx = idx_q;
    if (gt_max) begin
      nxt_max = elem;
      nxt_sec = max_val;
      nxt_idx = k;
    end else if (gt_sec) begin
      nxt_sec = elem;
    end
  end

  always_comb begin
    state_nxt    = state;
    layer_start  = '0;
    busy         = (state != S_IDLE);
    result_valid = (state == S_RESULT);
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_LAUNCH;
      end
      S_LAUNCH: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (cur_end) begin
          state_nxt = S_SCAN;
        end else if (!skip_hit) begin
          layer_start = cur_onehot;
          state_nxt   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort)          state_nxt = S_IDLE;
        else if (done_hit)  state_nxt = S_LAUNCH;
        else if (wd_expire) state_nxt = S_RESULT;
      end
      S_SCAN: begin
        if (abort)            state_nxt = S_IDLE;
        else if (k == K_LAST) state_nxt = S_RESULT;
      end
      S_RESULT: begin
        if (abort || result_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_overall_n) begin
    if (!rst_overall_n) begin
      state       <= S_IDLE;
      cur         <= '0;
      skip_q      <= '0;
      wdog        <= '0;
      k           <= '0;
      idx_q       <= '0;
      max_val     <= '0;
      sec_val     <= '0;
      pred_index  <= '0;
      pred_onehot <= '0;
      pred_value  <= '0;
      pred_margin <= '0;
      timeout_err <= 1'b0;
      for (int i = 0; i < OUT_ROWS; i++) snap[i] <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            skip_q      <= layer_skip_mask;
            cur         <= '0;
            timeout_err <= 1'b0;
          end
        end
        S_LAUNCH: begin
          if (!abort) begin
            if (cur_end) begin
              // ---- snapshot stage: freeze the final activations ----
              for (int i = 0; i < OUT_ROWS; i++)
                snap[i] <= final_vec[i*DATAWIDTH +: DATAWIDTH];
              k       <= '0;
              idx_q   <= '0;
              max_val <= MOST_NEG;
              sec_val <= MOST_NEG;
            end else if (skip_hit) begin
              cur <= cur + 1'b1;
            end else begin
              wdog <= '0;
            end
          end
        end
        S_WAIT: begin
          if (!abort) begin
            if (done_hit) begin
              cur <= cur + 1'b1;
            end else begin
              wdog <= wdog + 1'b1;
              if (wd_expire) begin
                timeout_err <= 1'b1;
                pred_index  <= '0;
                pred_onehot <= '0;
                pred_value  <= '0;
                pred_margin <= '0;
              end
            end
          end
        end
        S_SCAN: begin
          if (!abort) begin
            max_val <= nxt_max;
            sec_val <= nxt_sec;
            idx_q   <= nxt_idx;
            k       <= k + 1'b1;
            // ---- result stage: publish on the last element ----
            if (k == K_LAST) begin
              pred_value  <= nxt_max;
              pred_index  <= nxt_idx;
              pred_onehot <= OUT_ROWS'(1) << nxt_idx;
              pred_margin <= margin_calc(nxt_max, nxt_sec);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
